i2s_tx16: RTL and testbench

- Output stage directly downstream of the AGC.
- Accepts 16-bit I/Q samples (dix/diy with a one-cycle iv strobe) at the AGC output rate and buffers them in a small FIFO.
- Serializes them as standard I2S to an audio codec/DAC: I on the left channel, Q on the right.
- The bit clock is derived from the master clock by an integer divider. Status (FIFO level, sticky overflow/underflow) is readable by the host over the configuration port.

---
 rtl/i2s_tx16_pkg.sv | 23 ++
 rtl/i2s_tx16_sfifo32.sv | 72 +++++++
 rtl/i2s_tx16.sv | 126 ++++++++++++
 tb/tb_i2s_tx16.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx16_pkg.sv
// Shared constants and slot decoding for the i2s_tx16 serial output stage.
package i2s_tx16_pkg;

   localparam int OVF_BIT = 15;
   localparam int UNF_BIT = 14;
   localparam int SLOTS   = 32;
   localparam int WBITS   = 16;
   localparam int SW      = $clog2(SLOTS);

   // Slot 0 is the one-bit I2S delay, slots 1..16 carry the word MSB first, the rest pad with zero.
   function automatic logic slot_bit(input logic [WBITS-1:0] word, input logic [SW-1:0] s);
      logic [3:0] idx;
      logic       b;
      idx = 4'(5'd16 - s);
      if ((s >= 5'd1) && (s <= 5'd16)) begin
         b = word[idx];
      end else begin
         b = 1'b0;
      end
      return b;
   endfunction

endpackage

// File: rtl/i2s_tx16_sfifo32.sv
// Synchronous FIFO of {I,Q} words with occupancy count and drop/underflow events.
module sfifo32
   import i2s_tx16_pkg::*;
#(
   parameter int AW = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [2*WBITS-1:0]   wdata,
   output logic [2*WBITS-1:0]   rdata,
   output logic [AW:0]          count,
   output logic                 drop,
   output logic                 under
);

   localparam int          DW    = 2 * WBITS;
   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
   localparam logic [AW:0] CINC  = (AW+1)'(1);
   localparam logic [AW-1:0] PINC = AW'(1);

   logic [DW-1:0] mem_r [2**AW];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   count_r;
   logic          full_s;
   logic          empty_s;
   logic          push_ok_s;
   logic          pop_ok_s;

   // A pop is resolved first, so a full FIFO can still accept a push in the same cycle.
   always_comb begin
      full_s    = (count_r == DEPTH);
      empty_s   = (count_r == {(AW+1){1'b0}});
      pop_ok_s  = pop & ~empty_s;
      push_ok_s = push & (~full_s | pop_ok_s);
      drop      = push & ~push_ok_s;
      under     = pop & empty_s;
      count     = count_r;
      rdata     = mem_r[rptr_r];
   end

   // Storage array write.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wptr_r] <= wdata;
      end
   end

   // Pointer and occupancy update.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wptr_r <= wptr_r + PINC;
         end
         if (pop_ok_s) begin
            rptr_r <= rptr_r + PINC;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CINC;
            2'b01:   count_r <= count_r - CINC;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/i2s_tx16.sv
// I2S transmitter: buffers AGC I/Q samples and sends I on the left channel, Q on the right.
module i2s_tx16
   import i2s_tx16_pkg::*;
#(
   parameter int DIV = 4,
   parameter int AW  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] dix,
   input  logic [15:0] diy,
   input  logic        iv,
   input  logic        clr,
   output logic        sclk,
   output logic        lrck,
   output logic        sdo,
   output logic [15:0] cout
);

   localparam logic [7:0] DMAX = 8'(DIV - 1);

   logic [7:0]         dctr_r;
   logic               sclk_r;
   logic               tick_s;
   logic               fe_s;
   logic [5:0]         bctr_r;
   logic [5:0]         bnext_s;
   logic               lrck_r;
   logic               sdo_r;
   logic [WBITS-1:0]   i_r;
   logic [WBITS-1:0]   q_r;
   logic               load_s;
   logic [2*WBITS-1:0] head_s;
   logic [AW:0]        count_s;
   logic               drop_s;
   logic               under_s;
   logic               ovf_r;
   logic               unf_r;
   logic [15:0]        cout_s;
   logic [15:0]        cout_r;

   sfifo32 #(
      .AW(AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (iv),
      .pop   (load_s),
      .wdata ({dix, diy}),
      .rdata (head_s),
      .count (count_s),
      .drop  (drop_s),
      .under (under_s)
   );

   // Timing events and the status word assembled from current state.
   always_comb begin
      tick_s          = (dctr_r == DMAX);
      fe_s            = tick_s & sclk_r;
      bnext_s         = bctr_r + 6'd1;
      load_s          = fe_s & (bctr_r == 6'd63);
      cout_s          = 16'h0000;
      cout_s[AW:0]    = count_s;
      cout_s[OVF_BIT] = ovf_r;
      cout_s[UNF_BIT] = unf_r;
   end

   // Bit clock divider: sclk toggles every DIV master clocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         dctr_r <= 8'd0;
         sclk_r <= 1'b0;
      end else if (tick_s) begin
         dctr_r <= 8'd0;
         sclk_r <= ~sclk_r;
      end else begin
         dctr_r <= dctr_r + 8'd1;
      end
   end

   // Serializer: all serial outputs move on sclk falling edges; a new frame is latched at the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         bctr_r <= 6'd0;
         lrck_r <= 1'b0;
         sdo_r  <= 1'b0;
         i_r    <= 16'h0000;
         q_r    <= 16'h0000;
      end else if (fe_s) begin
         bctr_r <= bnext_s;
         lrck_r <= bnext_s[5];
         sdo_r  <= slot_bit(bnext_s[5] ? q_r : i_r, bnext_s[SW-1:0]);
         if (load_s) begin
            i_r <= under_s ? 16'h0000 : head_s[2*WBITS-1:WBITS];
            q_r <= under_s ? 16'h0000 : head_s[WBITS-1:0];
         end
      end
   end

   // Sticky flags (a new event beats clr) and the registered status port.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r  <= 1'b0;
         unf_r  <= 1'b0;
         cout_r <= 16'h0000;
      end else begin
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (clr) begin
            ovf_r <= 1'b0;
         end
         if (under_s) begin
            unf_r <= 1'b1;
         end else if (clr) begin
            unf_r <= 1'b0;
         end
         cout_r <= cout_s;
      end
   end

   assign sclk = sclk_r;
   assign lrck = lrck_r;
   assign sdo  = sdo_r;
   assign cout = cout_r;

endmodule

// File: tb/tb_i2s_tx16.sv
// Self-checking bench for i2s_tx16: queue-based reference model plus an I2S receiver.
module tb_i2s_tx16;

   localparam int DIV   = 4;
   localparam int AW    = 3;
   localparam int FRAME = 128 * DIV;
   localparam int DEPTH = 2 ** AW;

   typedef struct {
      logic [15:0] dix;
      logic [15:0] diy;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv;
   logic        clr;
   logic [15:0] dix;
   logic [15:0] diy;
   logic        sclk;
   logic        lrck;
   logic        sdo;
   logic [15:0] cout;

   i2s_tx16 #(.DIV(DIV), .AW(AW)) dut (
      .clk  (clk),
      .rst  (rst),
      .dix  (dix),
      .diy  (diy),
      .iv   (iv),
      .clr  (clr),
      .sclk (sclk),
      .lrck (lrck),
      .sdo  (sdo),
      .cout (cout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] mq[$];
   logic [31:0] fq[$];
   logic        m_ovf;
   logic        m_unf;
   int          cyc;
   int          gcyc = 0;
   bit          m_valid = 1'b0;

   // receiver state
   logic        rx_sclk_prev;
   logic        rx_lrck_prev;
   int          rx_pos;
   logic [15:0] rx_word;
   logic [15:0] rx_l;
   logic        rx_nz;
   int          rx_frames = 0;
   logic [31:0] rx_last = 32'h0;
   int          lr_rise[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   function automatic logic [15:0] status();
      logic [15:0] v;
      v       = 16'h0000;
      v[15]   = m_ovf;
      v[14]   = m_unf;
      v[AW:0] = (AW+1)'(mq.size());
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      fq.delete();
      fq.push_back(32'h0);
      m_ovf = 1'b0;
      m_unf = 1'b0;
      cyc   = 0;
   endtask

   // One master clock: frame boundary pops first, then the push is judged, then flags.
   task automatic model_step(input logic iv_v, input logic [31:0] w, input logic clr_v);
      logic ovf_e;
      logic unf_e;
      ovf_e = 1'b0;
      unf_e = 1'b0;
      cyc++;
      if (cyc % FRAME == 0) begin
         if (mq.size() > 0) begin
            fq.push_back(mq.pop_front());
         end else begin
            fq.push_back(32'h0);
            unf_e = 1'b1;
         end
      end
      if (iv_v) begin
         if (mq.size() < DEPTH) mq.push_back(w);
         else ovf_e = 1'b1;
      end
      if (ovf_e) m_ovf = 1'b1;
      else if (clr_v) m_ovf = 1'b0;
      if (unf_e) m_unf = 1'b1;
      else if (clr_v) m_unf = 1'b0;
   endtask

   task automatic rx_reset();
      rx_sclk_prev = 1'b0;
      rx_lrck_prev = 1'b0;
      rx_pos       = -1;
      rx_nz        = 1'b0;
      rx_word      = 16'h0;
      rx_l         = 16'h0;
   endtask

   // Standard I2S receiver: sample on sclk rise, data starts one bit after each lrck change.
   task automatic rx_sample();
      if (sclk && !rx_sclk_prev) begin
         if (lrck !== rx_lrck_prev) begin
            rx_pos = 0;
            if (lrck) lr_rise.push_back(gcyc);
         end else begin
            rx_pos++;
         end
         rx_lrck_prev = lrck;
         if (rx_pos >= 1 && rx_pos <= 16) rx_word = {rx_word[14:0], sdo};
         else if (sdo !== 1'b0) rx_nz = 1'b1;
         if (rx_pos == 31) begin
            chk("pad_zero", 32'(rx_nz), 32'd0);
            rx_nz = 1'b0;
            if (!lrck) begin
               rx_l = rx_word;
            end else begin
               rx_last = {rx_l, rx_word};
               rx_frames++;
               chk("frame_queued", 32'(fq.size() > 0), 32'd1);
               if (fq.size() > 0) chk("frame_data", rx_last, fq.pop_front());
            end
         end
      end
      rx_sclk_prev = sclk;
   endtask

   task automatic step(input logic iv_v, input logic [15:0] x, input logic [15:0] y,
                       input logic clr_v, input logic rst_v);
      logic [15:0] prev_stat;
      rst = rst_v;
      iv  = iv_v;
      dix = x;
      diy = y;
      clr = clr_v;
      @(posedge clk);
      gcyc++;
      prev_stat = status();
      if (rst_v) model_reset();
      else model_step(iv_v, {x, y}, clr_v);
      @(negedge clk);
      if (m_valid) chk("cout", 32'(cout), rst_v ? 32'h0 : 32'(prev_stat));
      m_valid = 1'b1;
      if (rst_v) rx_reset();
      else rx_sample();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   // Run idle until the next edge lands at frame position p.
   task automatic wait_pos(input int p);
      while (((cyc + 1) % FRAME) != p) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tbl [4];
      int   f0;
      int   n;
      bit   seen_hi;

      tbl[0] = '{16'hA5C3, 16'h0F01, 16'hA5C3, 16'h0F01};
      tbl[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
      tbl[2] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
      tbl[3] = '{16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA};

      rst = 1'b1; iv = 1'b0; clr = 1'b0; dix = 16'h0; diy = 16'h0;
      model_reset();
      rx_reset();
      repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      chk("reset_sclk", 32'(sclk), 32'd0);
      chk("reset_lrck", 32'(lrck), 32'd0);
      chk("reset_sdo",  32'(sdo),  32'd0);
      chk("reset_cout", 32'(cout), 32'd0);

      // single samples into an empty FIFO
      for (int k = 0; k < 4; k++) begin
         wait_pos(10);
         step(1'b1, tbl[k].dix, tbl[k].diy, 1'b0, 1'b0);
         f0 = rx_frames;
         n  = 0;
         while (rx_frames < f0 + 2 && n < 3 * FRAME) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            n++;
         end
         chk("tbl_wait", 32'(n < 3 * FRAME), 32'd1);
         chk("tbl_left",  32'(rx_last[31:16]), 32'(tbl[k].exp_l));
         chk("tbl_right", 32'(rx_last[15:0]),  32'(tbl[k].exp_r));
      end
      chk("lrck_seen", 32'(lr_rise.size() >= 2), 32'd1);
      if (lr_rise.size() >= 2) chk("lrck_period", 32'(lr_rise[1] - lr_rise[0]), 32'(FRAME));

      // underflow, clear, and re-assertion at the next boundary
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      idle(3 * FRAME);
      chk("unf_set", 32'(cout[14]), 32'd1);
      wait_pos(100);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      idle(2);
      chk("unf_clr", 32'(cout[14]), 32'd0);
      wait_pos(1);
      idle(2);
      chk("unf_again", 32'(cout[14]), 32'd1);

      // overflow: nine back-to-back strobes within one frame
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      wait_pos(20);
      for (int k = 0; k < 9; k++) step(1'b1, 16'h1100 | 16'(k), 16'h2200 | 16'(k), 1'b0, 1'b0);
      idle(2);
      chk("ovf_count", 32'(cout[AW:0]), 32'(DEPTH));
      chk("ovf_flag",  32'(cout[15]),   32'd1);

      // full FIFO push in the wrap cycle
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      wait_pos(0);
      step(1'b1, 16'hBEEF, 16'hCAFE, 1'b0, 1'b0);
      idle(2);
      chk("fpp_count", 32'(cout[AW:0]), 32'(DEPTH));
      chk("fpp_ovf",   32'(cout[15]),   32'd0);
      idle(10 * FRAME);

      // empty FIFO push in the wrap cycle
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      wait_pos(0);
      step(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0);
      idle(2);
      chk("epp_unf",   32'(cout[14]),   32'd1);
      chk("epp_count", 32'(cout[AW:0]), 32'd1);
      idle(3 * FRAME);

      // reset mid-frame with data queued
      wait_pos(100);
      for (int k = 0; k < 3; k++) step(1'b1, 16'h7700 | 16'(k), 16'h6600 | 16'(k), 1'b0, 1'b0);
      wait_pos(322);
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      chk("mrst_sclk", 32'(sclk), 32'd0);
      chk("mrst_lrck", 32'(lrck), 32'd0);
      chk("mrst_sdo",  32'(sdo),  32'd0);
      chk("mrst_cout", 32'(cout), 32'd0);
      n = 0;
      seen_hi = 1'b0;
      while (n < 4 * DIV) begin
         step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
         n++;
         if (sclk) seen_hi = 1'b1;
         else if (seen_hi) break;
      end
      chk("first_fall", 32'(n), 32'(2 * DIV));
      idle(2 * FRAME);

      // randomized traffic, busy then sparse
      for (int k = 0; k < 16 * FRAME; k++) begin
         step(($urandom_range(0, 999) < ((k < 8 * FRAME) ? 4 : 1)),
              16'($urandom), 16'($urandom),
              ($urandom_range(0, 999) == 0), 1'b0);
      end
      idle(2 * FRAME);
      chk("frames_seen", 32'(rx_frames >= 40), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
